// File: rtl/ex_fwd_ctrl.sv
// EX-stage operand select generator: tracks EX/WB destination metadata and
// registers the asel/bsel forwarding codes for the instruction entering EX.
module ex_fwd_ctrl #(
  parameter int XLEN_CNT      = 32,
  parameter int NUM_REGS_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [NUM_REGS_LOG2-1:0] id_rs1,
  input  logic [NUM_REGS_LOG2-1:0] id_rs2,
  input  logic [NUM_REGS_LOG2-1:0] id_rd,
  input  logic                     id_regwen,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic                     id_a_pc,
  input  logic                     id_b_imm,
  input  logic                     cnt_clr,
  output logic [1:0]               asel,
  output logic [1:0]               bsel,
  output logic                     ex_valid,
  output logic                     wb_valid,
  output logic [NUM_REGS_LOG2-1:0] wb_rd,
  output logic                     wb_regwen,
  output logic [XLEN_CNT-1:0]      fwd_count
);

  logic [NUM_REGS_LOG2-1:0] ex_rd;
  logic                     ex_regwen;
  logic                     take;
  logic                     ex_wr_live;
  logic                     fwd1;
  logic                     fwd2;
  logic                     fwd_evt;

  // Only the instruction about to enter WB is a forwarding source; older
  // writers are covered by the register file's write-before-read bypass.
  always_comb begin
    take       = id_valid & ~flush;
    ex_wr_live = ex_valid & ex_regwen & (ex_rd != '0);
    fwd1       = take & id_uses_rs1 & ex_wr_live & (id_rs1 == ex_rd);
    fwd2       = take & id_uses_rs2 & ex_wr_live & (id_rs2 == ex_rd);
    fwd_evt    = ex_valid & (asel[1] | bsel[1]);
  end

  // ID -> EX and EX -> WB slot advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_regwen <= 1'b0;
      asel      <= 2'b00;
      bsel      <= 2'b00;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_regwen <= 1'b0;
      fwd_count <= '0;
    end else if (!stall) begin
      wb_valid  <= ex_valid;
      wb_rd     <= ex_rd;
      wb_regwen <= ex_regwen & ex_valid;
      ex_valid  <= take;
      ex_rd     <= take ? id_rd : '0;
      ex_regwen <= take & id_regwen;
      asel      <= take ? {fwd1, id_a_pc}  : 2'b00;
      bsel      <= take ? {fwd2, id_b_imm} : 2'b00;
      if (cnt_clr)
        fwd_count <= '0;
      else
        fwd_count <= fwd_count + {{(XLEN_CNT-1){1'b0}}, fwd_evt};
    end
  end

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Scoreboard bench for ex_fwd_ctrl: driver pushes expected post-edge state from
// an instruction-history model; a monitor pops and compares after every edge.
module tb_ex_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic        id_valid = 1'b0, id_regwen = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_a_pc = 1'b0, id_b_imm = 1'b0;
  logic [1:0]  asel, bsel;
  logic        ex_valid, wb_valid, wb_regwen;
  logic [4:0]  wb_rd;
  logic [31:0] fwd_count;

  always #5 clk = ~clk;

  ex_fwd_ctrl #(.XLEN_CNT(32), .NUM_REGS_LOG2(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwen(id_regwen), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .cnt_clr(cnt_clr),
    .asel(asel), .bsel(bsel), .ex_valid(ex_valid), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_regwen(wb_regwen), .fwd_count(fwd_count)
  );

  typedef struct packed {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic rw; logic u1; logic u2; logic apc; logic bimm;
  } ins_t;

  // One entry per accepted pipeline advance: what occupied EX from then on.
  typedef struct packed {
    logic valid; logic [4:0] rd; logic rw; logic fa; logic fb; logic apc; logic bimm;
  } rec_t;

  typedef struct packed {
    logic [1:0] asel; logic [1:0] bsel; logic exv; logic wbv;
    logic [4:0] wbrd; logic wbrw; logic [31:0] cnt;
  } exp_t;

  rec_t        hist[$];
  exp_t        exp_q[$];
  logic [31:0] cnt_m;
  int          checks = 0;
  int          errors = 0;
  bit          started = 0;

  function automatic void model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    cnt_m = '0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    rec_t ex, wb;
    ex = hist[hist.size()-1];
    wb = hist[hist.size()-2];
    e.asel = ex.valid ? {ex.fa, ex.apc}  : 2'b00;
    e.bsel = ex.valid ? {ex.fb, ex.bimm} : 2'b00;
    e.exv  = ex.valid;
    e.wbv  = wb.valid;
    e.wbrd = wb.rd;
    e.wbrw = wb.valid & wb.rw;
    e.cnt  = cnt_m;
    return e;
  endfunction

  function automatic void model_edge(ins_t i, logic st, logic fl, logic clr);
    rec_t ex, n;
    if (st) return;
    ex = hist[hist.size()-1];
    if (clr) cnt_m = '0;
    else if (ex.valid && (ex.fa || ex.fb)) cnt_m = cnt_m + 1;
    n = '0;
    if (i.v && !fl) begin
      n.valid = 1'b1;
      n.rd    = i.rd;
      n.rw    = i.rw;
      n.apc   = i.apc;
      n.bimm  = i.bimm;
      n.fa    = i.u1 && ex.valid && ex.rw && (ex.rd != 0) && (i.rs1 == ex.rd);
      n.fb    = i.u2 && ex.valid && ex.rw && (ex.rd != 0) && (i.rs2 == ex.rd);
    end
    hist.push_back(n);
    if (hist.size() > 4) void'(hist.pop_front());
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input ins_t i, input logic r, input logic st, input logic fl, input logic clr);
    @(negedge clk);
    rst = r; stall = st; flush = fl; cnt_clr = clr;
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_regwen = i.rw;
    id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_a_pc = i.apc; id_b_imm = i.bimm;
    if (r) model_reset();
    else model_edge(i, st, fl, clr);
    exp_q.push_back(model_out());
    started = 1;
  endtask

  function automatic ins_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic rw, logic u1, logic u2, logic apc, logic bimm);
    ins_t i;
    i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.rw = rw;
    i.u1 = u1; i.u2 = u2; i.apc = apc; i.bimm = bimm;
    return i;
  endfunction

  // Reset asserted between edges must clear outputs immediately.
  task automatic areset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("areset_asel", {30'd0, asel}, 32'd0);
    check("areset_bsel", {30'd0, bsel}, 32'd0);
    check("areset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("areset_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("areset_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("areset_wb_regwen", {31'd0, wb_regwen}, 32'd0);
    check("areset_fwd_count", fwd_count, 32'd0);
    step('0, 1'b1, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("asel", {30'd0, asel}, {30'd0, e.asel});
          check("bsel", {30'd0, bsel}, {30'd0, e.bsel});
          check("ex_valid", {31'd0, ex_valid}, {31'd0, e.exv});
          check("wb_valid", {31'd0, wb_valid}, {31'd0, e.wbv});
          if (e.wbv) check("wb_rd", {27'd0, wb_rd}, {27'd0, e.wbrd});
          check("wb_regwen", {31'd0, wb_regwen}, {31'd0, e.wbrw});
          check("fwd_count", fwd_count, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    ins_t idle, ri;
    idle = '0;
    model_reset();
    step(idle, 1'b1, 1'b0, 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0, 1'b0, 1'b0);
    // addi x5 ; add x6,x5,x5
    step(mk(1, 0, 0, 5, 1, 1, 0, 0, 1), 0, 0, 0, 0);
    step(mk(1, 5, 5, 6, 1, 1, 1, 0, 0), 0, 0, 0, 0);
    step(idle, 0, 0, 0, 0);
    // lui x0 ; consumer of x0 ; jal
    step(mk(1, 0, 0, 0, 1, 0, 0, 0, 1), 0, 0, 0, 0);
    step(mk(1, 0, 0, 8, 1, 1, 0, 0, 0), 0, 0, 0, 0);
    step(mk(1, 0, 0, 1, 1, 0, 0, 1, 1), 0, 0, 0, 0);
    // writer x3 ; beq x3,x4
    step(mk(1, 0, 0, 3, 1, 1, 0, 0, 1), 0, 0, 0, 0);
    step(mk(1, 3, 4, 0, 0, 1, 1, 1, 0), 0, 0, 0, 0);
    // flush of a dependent instruction
    step(mk(1, 0, 0, 7, 1, 0, 0, 0, 1), 0, 0, 0, 0);
    step(mk(1, 7, 7, 2, 1, 1, 1, 0, 0), 0, 0, 1, 0);
    step(idle, 0, 0, 0, 0);
    // stall while EX holds a forwarding instruction; flush pulsed meanwhile
    step(mk(1, 0, 0, 9, 1, 0, 0, 0, 1), 0, 0, 0, 0);
    step(mk(1, 9, 1, 10, 1, 1, 0, 0, 0), 0, 0, 0, 0);
    step(mk(1, 10, 10, 11, 1, 1, 1, 0, 0), 0, 1, 0, 1);
    step(mk(1, 10, 10, 11, 1, 1, 1, 0, 0), 0, 1, 1, 0);
    step(mk(1, 10, 10, 11, 1, 1, 1, 0, 0), 0, 1, 0, 0);
    step(mk(1, 10, 10, 11, 1, 1, 1, 0, 0), 0, 0, 0, 0);
    // clear, then a dependency chain bringing fwd_count to 7 with asel=10 in EX
    step(mk(1, 0, 0, 5, 1, 0, 0, 0, 1), 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) step(mk(1, 5, 0, 5, 1, 1, 0, 0, 0), 0, 0, 0, 0);
    areset();
    // randomized traffic over a small register range to force frequent matches
    for (int n = 0; n < 1500; n++) begin
      ri.v    = ($urandom_range(0, 9) != 0);
      ri.rs1  = 5'($urandom_range(0, 3));
      ri.rs2  = 5'($urandom_range(0, 3));
      ri.rd   = 5'($urandom_range(0, 3));
      ri.rw   = ($urandom_range(0, 3) != 0);
      ri.u1   = 1'($urandom);
      ri.u2   = 1'($urandom);
      ri.apc  = 1'($urandom);
      ri.bimm = 1'($urandom);
      if ($urandom_range(0, 299) == 0) areset();
      step(ri, 1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 19) == 0));
    end
    @(posedge clk);
    #2;
    started = 0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
